// File: rtl/logreg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logreg_pkg -- shared sizes, FSM encoding and per-class theta tables.      |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
package logreg_pkg;

    localparam int N_FEAT  = 81;
    localparam int N_CLASS = 10;
    localparam int XW      = 7;
    localparam int TW      = 32;
    localparam int CLS_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Theta table selectors; each models one per-class coefficient header set.
    localparam int THETA_RAMP    = 0;
    localparam int THETA_ZERO    = 1;
    localparam int THETA_ONE_POS = 2;
    localparam int THETA_C0_MAX  = 3;

    function automatic logic [TW-1:0] theta_value(input int sel, input int c, input int i);
        logic [TW-1:0] v;
        v = '0;
        if (c < N_CLASS && i < N_FEAT) begin
            case (sel)
                THETA_RAMP:    v = TW'(c);
                THETA_ZERO:    v = '0;
                THETA_ONE_POS: v = (c == 3) ? TW'(1) : '1;
                THETA_C0_MAX:  v = (c == 0) ? {1'b0, {(TW-1){1'b1}}} : '0;
                default:       v = '0;
            endcase
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logreg_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logreg_sched_if -- feature stream in, classification result out.         |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface logreg_sched_if #(
    parameter int XW    = logreg_pkg::XW,
    parameter int TW    = logreg_pkg::TW,
    parameter int CLS_W = logreg_pkg::CLS_W
);
    logic             in_valid;
    logic             in_ready;
    logic [XW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CLS_W-1:0] out_class;
    logic [TW-1:0]    out_score;
    logic             busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_class, out_score, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_class, out_score, busy
    );
endinterface
`default_nettype wire

// File: rtl/theta_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | theta_rom -- N_CLASS x N_FEAT coefficient ROM, address {c,i}, 1-cycle read|
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module theta_rom #(
    parameter  int N_FEAT    = logreg_pkg::N_FEAT,
    parameter  int TW        = logreg_pkg::TW,
    parameter  int THETA_SEL = logreg_pkg::THETA_RAMP,
    localparam int FW        = $clog2(N_FEAT),
    localparam int AW        = logreg_pkg::CLS_W + FW
) (
    input  wire           clk,
    input  wire  [AW-1:0] addr,
    output logic [TW-1:0] data
);
    import logreg_pkg::*;

    always_ff @(posedge clk) begin
        data <= theta_value(THETA_SEL, int'(addr[AW-1:FW]), int'(addr[FW-1:0]));
    end

endmodule
`default_nettype wire

// File: rtl/logreg_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logreg_sched -- one-vs-all logistic-regression scorer, one MAC per cycle. |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module logreg_sched #(
    parameter int N_FEAT    = logreg_pkg::N_FEAT,
    parameter int N_CLASS   = logreg_pkg::N_CLASS,
    parameter int XW        = logreg_pkg::XW,
    parameter int TW        = logreg_pkg::TW,
    parameter int THETA_SEL = logreg_pkg::THETA_RAMP
) (
    input  wire           clk,
    input  wire           rst_n,
    logreg_sched_if.slave bus
);
    import logreg_pkg::*;

    localparam int FW = $clog2(N_FEAT);
    localparam int AW = CLS_W + FW;

    state_t             state;
    state_t             state_nx;
    logic               in_ready;
    logic               out_valid;
    logic               busy;

    logic [FW-1:0]      feat_cnt;
    logic [CLS_W-1:0]   class_cnt;
    logic               issued_all;
    logic [XW-1:0]      feat_buf [N_FEAT];

    logic               p_vld;
    logic [FW-1:0]      p_feat;
    logic [CLS_W-1:0]   p_class;
    logic               p_first;
    logic               p_last_feat;
    logic               p_final;

    logic [TW-1:0]      rom_data;
    logic [TW-1:0]      x_ext;
    logic [TW-1:0]      prod;
    logic [TW-1:0]      acc;
    logic [TW-1:0]      acc_sum;
    logic [TW-1:0]      best_score;
    logic [CLS_W-1:0]   best_class;
    logic               take;
    logic [TW-1:0]      win_score;
    logic [CLS_W-1:0]   win_class;
    logic [TW-1:0]      out_score_r;
    logic [CLS_W-1:0]   out_class_r;

    logic               accept;
    logic               issue;
    logic               last_feat;
    logic               last_class;

    assign accept     = bus.in_valid & in_ready;
    assign issue      = (state == ST_COMPUTE) && !issued_all;
    assign last_feat  = (feat_cnt == FW'(N_FEAT - 1));
    assign last_class = (class_cnt == CLS_W'(N_CLASS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid && last_feat) state_nx = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (p_vld && p_final) state_nx = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Sample storage is not reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept) feat_buf[feat_cnt] <= bus.in_data;
    end

    theta_rom #(
        .N_FEAT    (N_FEAT),
        .TW        (TW),
        .THETA_SEL (THETA_SEL)
    ) u_theta_rom (
        .clk  (clk),
        .addr ({class_cnt, feat_cnt}),
        .data (rom_data)
    );

    // MAC stage runs one cycle behind the address counters to meet ROM latency.
    assign p_first     = (p_feat == '0);
    assign p_last_feat = (p_feat == FW'(N_FEAT - 1));
    assign p_final     = p_last_feat && (p_class == CLS_W'(N_CLASS - 1));
    assign x_ext       = {{(TW-XW){1'b0}}, feat_buf[p_feat]};
    assign prod        = x_ext * rom_data;
    assign acc_sum     = (p_first ? '0 : acc) + prod;
    assign take        = (p_class == '0) || ($signed(acc_sum) > $signed(best_score));
    assign win_score   = take ? acc_sum : best_score;
    assign win_class   = take ? p_class : best_class;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_cnt    <= '0;
            class_cnt   <= '0;
            issued_all  <= 1'b0;
            p_vld       <= 1'b0;
            p_feat      <= '0;
            p_class     <= '0;
            acc         <= '0;
            best_score  <= '0;
            best_class  <= '0;
            out_score_r <= '0;
            out_class_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) feat_cnt <= FW'(1);
                end
                ST_LOAD: begin
                    if (accept) feat_cnt <= last_feat ? '0 : feat_cnt + 1'b1;
                end
                ST_COMPUTE: begin
                    if (issue) begin
                        if (last_feat) begin
                            feat_cnt <= '0;
                            if (last_class) begin
                                class_cnt  <= '0;
                                issued_all <= 1'b1;
                            end else begin
                                class_cnt <= class_cnt + 1'b1;
                            end
                        end else begin
                            feat_cnt <= feat_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    issued_all <= 1'b0;
                end
                default: ;
            endcase

            p_vld   <= issue;
            p_feat  <= feat_cnt;
            p_class <= class_cnt;

            if (p_vld) begin
                acc <= acc_sum;
                if (p_last_feat) begin
                    best_score <= win_score;
                    best_class <= win_class;
                end
                if (p_final) begin
                    out_score_r <= win_score;
                    out_class_r <= win_class;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.out_class = out_class_r;
    assign bus.out_score = out_score_r;

endmodule
`default_nettype wire
